shift_add_mult: RTL and testbench

Sequential 8x8 unsigned shift-and-add multiplier that sits directly upstream of the 16-bit ripple-carry `fadder`. The multiplier drives the adder's operands once per cycle and registers its sum into a partial-product accumulator. It produces a 16-bit product after a fixed 8-step iteration and uses a start/busy/done handshake. It is the integer mantissa-product stage feeding the FMAC datapath.

---
 rtl/fmac_pkg.sv | 21 ++
 rtl/fadder.sv | 28 ++
 rtl/shift_add_mult.sv | 98 +++++++++
 tb/tb_shift_add_mult.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fmac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fmac_pkg
//  Purpose  : Shared types and width constants for the FMAC mantissa datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package fmac_pkg;

    localparam int MANT_W = 8;
    localparam int PROD_W = 16;
    localparam int STEPS  = 8;
    localparam int CNT_W  = $clog2(STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : fmac_pkg
`default_nettype wire

// File: rtl/fadder.sv
`default_nettype none
// ============================================================================
//  Module   : fadder
//  Purpose  : 16-bit combinational ripple-carry adder, carry-in fixed at 0.
//  Revision : 1.0 - initial release
// ============================================================================
module fadder
    import fmac_pkg::*;
(
    input  logic [PROD_W-1:0] a,
    input  logic [PROD_W-1:0] b,
    output logic [PROD_W-1:0] s,
    output logic              co
);

    logic [PROD_W:0] w_carry;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < PROD_W; i++) begin : g_bit
        assign s[i]         = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign co = w_carry[PROD_W];

endmodule : fadder
`default_nettype wire

// File: rtl/shift_add_mult.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_mult
//  Purpose  : Sequential 8x8 unsigned shift-and-add multiplier, fixed 8 steps,
//             start/busy/done handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_add_mult
    import fmac_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MANT_W-1:0] a,
    input  logic [MANT_W-1:0] b,
    output logic [PROD_W-1:0] product,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(STEPS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PROD_W-1:0]   r_acc;
    logic [PROD_W-1:0]   r_mcand;
    logic [MANT_W-1:0]   r_mplier;
    logic [CNT_W-1:0]    r_cnt;
    logic [PROD_W-1:0]   r_product;
    logic [PROD_W-1:0]   w_sum;
    logic [PROD_W-1:0]   w_acc_nxt;
    logic                w_co_unused;

    fadder u_fadder (
        .a  (r_acc),
        .b  (r_mcand),
        .s  (w_sum),
        .co (w_co_unused)
    );

    assign w_acc_nxt = r_mplier[0] ? w_sum : r_acc;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (r_cnt == C_LAST_STEP) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: operands captured only on an accepted start, then 8 shift/add steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc    <= '0;
                        r_mcand  <= {{(PROD_W-MANT_W){1'b0}}, a};
                        r_mplier <= b;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST_STEP) begin
                        r_product <= w_acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign product = r_product;
    assign busy    = (r_state == RUN);
    assign done    = (r_state == DONE);

endmodule : shift_add_mult
`default_nettype wire

// File: tb/tb_shift_add_mult.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_add_mult
//  Purpose  : Self-checking bench for shift_add_mult against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] product;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    shift_add_mult dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // The adder carry-out must stay low whenever a multiplication is in flight.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && busy === 1'b1) begin
            checks++;
            assert (dut.u_fadder.co === 1'b0) else begin
                errors++;
                $error("FAIL fadder_co observed %b expected 0", dut.u_fadder.co);
            end
        end
        if (busy === 1'b1 && done === 1'b1) begin
            checks++;
            errors++;
            $error("FAIL busy_and_done observed 1 expected 0");
        end
    end

    // One full operation; optionally re-pulse start and scramble operands mid-RUN.
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input bit perturb,
                         input string tag);
        logic [15:0] exp_p;
        logic [15:0] got_p;
        int nb;
        int nd;
        int done_at;
        exp_p   = 16'(ia) * 16'(ib);
        nb      = 0;
        nd      = 0;
        done_at = -1;
        got_p   = 'x;
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (perturb && k == 3) begin
                start = 1'b1;
                a = ~ia;
                b = ~ib;
            end
            if (perturb && k == 5) start = 1'b0;
            if (busy) nb++;
            if (done) begin
                nd++;
                if (done_at < 0) begin
                    done_at = k;
                    got_p   = product;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, nb, 8);
        check({tag, "_done_count"}, nd, 1);
        check({tag, "_latency"}, done_at, 8);
        check({tag, "_product"}, got_p, exp_p);
        check({tag, "_product_hold"}, product, exp_p);
    endtask

    initial begin
        int t1;
        int t2;
        logic [15:0] p1;
        logic [15:0] p2;
        logic [7:0] ra;
        logic [7:0] rb;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset_product", product, 16'h0000);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'h0D, 8'h0B, 1'b0, "d_0d_0b");
        do_op(8'hFF, 8'hFF, 1'b0, "d_ff_ff");
        do_op(8'h00, 8'hFF, 1'b0, "d_00_ff");
        do_op(8'hA5, 8'h00, 1'b0, "d_a5_00");
        do_op(8'h07, 8'h09, 1'b1, "perturb_07_09");

        // Start held high: back-to-back operations, operands swapped after first accept.
        @(negedge clk);
        a = 8'h12;
        b = 8'h34;
        start = 1'b1;
        @(negedge clk);
        a = 8'h03;
        b = 8'h05;
        t1 = -1;
        t2 = -1;
        p1 = 'x;
        p2 = 'x;
        for (int k = 0; k < 19; k++) begin
            if (done) begin
                if (t1 < 0) begin
                    t1 = k;
                    p1 = product;
                end else if (t2 < 0) begin
                    t2 = k;
                    p2 = product;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("held_first_product", p1, 16'h03A8);
        check("held_second_product", p2, 16'h000F);
        check("held_done_spacing", t2 - t1, 10);
        repeat (12) @(negedge clk);

        // Asynchronous reset in the middle of 0xFF*0xFF.
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_abort_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_product", product, 16'h0000);
        check("abort_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'h02, 8'h03, 1'b0, "post_reset");

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_op(ra, rb, (i % 4) == 3, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shift_add_mult
`default_nettype wire
